// File: rtl/glb_router_cluster.sv
// One hierarchical-mesh NoC cluster: iact/wght/psum global-buffer banks plus three
// identical combinational 4-port routers. GLB read data feeds the iact/wght west inputs.

module glb_router_cluster_bank #(
    parameter int DW = 16,
    parameter int AW = 10,
    parameter int NB = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    localparam int DEPTH = NB * (2 ** AW);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-address read/write returns the old word; the output register holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

module glb_router_cluster_router #(
    parameter int DW = 16
) (
    input  logic [3:0]    mode_i,
    input  logic [DW-1:0] west_data_i,
    input  logic          west_enable_i,
    input  logic [DW-1:0] east_data_i,
    input  logic          east_enable_i,
    input  logic [DW-1:0] north_data_i,
    input  logic          north_enable_i,
    input  logic [DW-1:0] south_data_i,
    input  logic          south_enable_i,
    output logic [DW-1:0] west_data_o,
    output logic          west_enable_o,
    output logic [DW-1:0] east_data_o,
    output logic          east_enable_o,
    output logic [DW-1:0] north_data_o,
    output logic          north_enable_o,
    output logic [DW-1:0] south_data_o,
    output logic          south_enable_o
);
    localparam logic [1:0] P_W = 2'd0;
    localparam logic [1:0] P_E = 2'd1;
    localparam logic [1:0] P_N = 2'd2;
    localparam logic [1:0] P_S = 2'd3;

    localparam logic [3:0] M_W = 4'b0001;
    localparam logic [3:0] M_E = 4'b0010;
    localparam logic [3:0] M_N = 4'b0100;
    localparam logic [3:0] M_S = 4'b1000;

    localparam logic [3:0] MODE_ALL       = 4'd0;
    localparam logic [3:0] MODE_NORTH     = 4'd1;
    localparam logic [3:0] MODE_SOUTH     = 4'd2;
    localparam logic [3:0] MODE_WEST      = 4'd3;
    localparam logic [3:0] MODE_EAST      = 4'd4;
    localparam logic [3:0] MODE_EASTNORTH = 4'd5;
    localparam logic [3:0] MODE_EASTSOUTH = 4'd6;
    localparam logic [3:0] MODE_EASTWEST  = 4'd7;
    localparam logic [3:0] MODE_WESTNORTH = 4'd8;
    localparam logic [3:0] MODE_WESTSOUTH = 4'd9;
    localparam logic [3:0] MODE_WESTEAST  = 4'd10;

    logic [DW-1:0] in_data  [4];
    logic [DW-1:0] out_data [4];
    logic [3:0]    in_en;
    logic [3:0]    out_en;
    logic [1:0]    first_en;
    logic [1:0]    src_sel;
    logic [3:0]    dst_mask;
    logic          any_en;

    assign in_data[P_W] = west_data_i;
    assign in_data[P_E] = east_data_i;
    assign in_data[P_N] = north_data_i;
    assign in_data[P_S] = south_data_i;
    assign in_en        = {south_enable_i, north_enable_i, east_enable_i, west_enable_i};
    assign any_en       = |in_en;

    // Destination-only modes take the first enabled input: west > east > north > south.
    always_comb begin
        first_en = P_S;
        if (in_en[P_W]) begin
            first_en = P_W;
        end else if (in_en[P_E]) begin
            first_en = P_E;
        end else if (in_en[P_N]) begin
            first_en = P_N;
        end
    end

    always_comb begin
        src_sel  = P_W;
        dst_mask = '0;
        case (mode_i)
            MODE_ALL:       dst_mask = M_N | M_S | M_E;
            MODE_NORTH:     begin src_sel = first_en; dst_mask = any_en ? M_N : '0; end
            MODE_SOUTH:     begin src_sel = first_en; dst_mask = any_en ? M_S : '0; end
            MODE_WEST:      begin src_sel = first_en; dst_mask = any_en ? M_W : '0; end
            MODE_EAST:      begin src_sel = first_en; dst_mask = any_en ? M_E : '0; end
            MODE_EASTNORTH: begin src_sel = P_E; dst_mask = M_N; end
            MODE_EASTSOUTH: begin src_sel = P_E; dst_mask = M_S; end
            MODE_EASTWEST:  begin src_sel = P_E; dst_mask = M_W; end
            MODE_WESTNORTH: begin src_sel = P_W; dst_mask = M_N; end
            MODE_WESTSOUTH: begin src_sel = P_W; dst_mask = M_S; end
            MODE_WESTEAST:  begin src_sel = P_W; dst_mask = M_E; end
            default:        dst_mask = '0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_out
            assign out_data[gi] = dst_mask[gi] ? in_data[src_sel] : '0;
            assign out_en[gi]   = dst_mask[gi] & in_en[src_sel];
        end
    endgenerate

    assign west_data_o    = out_data[P_W];
    assign west_enable_o  = out_en[P_W];
    assign east_data_o    = out_data[P_E];
    assign east_enable_o  = out_en[P_E];
    assign north_data_o   = out_data[P_N];
    assign north_enable_o = out_en[P_N];
    assign south_data_o   = out_data[P_S];
    assign south_enable_o = out_en[P_S];
endmodule

module glb_router_cluster #(
    parameter int DATA_WIDTH    = 16,
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int NUM_GLB_IACT  = 1,
    parameter int NUM_GLB_PSUM  = 1,
    parameter int NUM_GLB_WGHT  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     read_req_iact,
    input  logic                     read_req_wght,
    input  logic                     read_req_psum,
    input  logic [ADDR_BITWIDTH-1:0] r_addr_iact,
    input  logic [ADDR_BITWIDTH-1:0] r_addr_wght,
    input  logic [ADDR_BITWIDTH-1:0] r_addr_psum,
    input  logic                     write_en_iact,
    input  logic                     write_en_wght,
    input  logic [ADDR_BITWIDTH-1:0] w_addr_iact,
    input  logic [ADDR_BITWIDTH-1:0] w_addr_wght,
    input  logic [ADDR_BITWIDTH-1:0] w_addr_psum,
    input  logic [DATA_BITWIDTH-1:0] w_data_iact,
    input  logic [DATA_BITWIDTH-1:0] w_data_wght,
    output logic [DATA_BITWIDTH-1:0] r_data_psum,
    input  logic [3:0]               router_mode_iact,
    input  logic [3:0]               router_mode_wght,
    input  logic [3:0]               router_mode_psum,
    input  logic [DATA_WIDTH-1:0]    north_data_i_iact,
    input  logic                     north_enable_i_iact,
    input  logic [DATA_WIDTH-1:0]    south_data_i_iact,
    input  logic                     south_enable_i_iact,
    input  logic [DATA_WIDTH-1:0]    east_data_i_iact,
    input  logic                     east_enable_i_iact,
    input  logic                     west_enable_i_iact,
    input  logic [DATA_WIDTH-1:0]    north_data_i_wght,
    input  logic                     north_enable_i_wght,
    input  logic [DATA_WIDTH-1:0]    south_data_i_wght,
    input  logic                     south_enable_i_wght,
    input  logic [DATA_WIDTH-1:0]    east_data_i_wght,
    input  logic                     east_enable_i_wght,
    input  logic                     west_enable_i_wght,
    input  logic [DATA_WIDTH-1:0]    north_data_i_psum,
    input  logic                     north_enable_i_psum,
    input  logic [DATA_WIDTH-1:0]    south_data_i_psum,
    input  logic                     south_enable_i_psum,
    input  logic [DATA_WIDTH-1:0]    east_data_i_psum,
    input  logic                     east_enable_i_psum,
    input  logic [DATA_WIDTH-1:0]    west_data_i_psum,
    input  logic                     west_enable_i_psum,
    output logic [DATA_WIDTH-1:0]    north_data_o_iact,
    output logic                     north_enable_o_iact,
    output logic [DATA_WIDTH-1:0]    south_data_o_iact,
    output logic                     south_enable_o_iact,
    output logic [DATA_WIDTH-1:0]    east_data_o_iact,
    output logic                     east_enable_o_iact,
    output logic [DATA_WIDTH-1:0]    west_data_o_iact,
    output logic                     west_enable_o_iact,
    output logic [DATA_WIDTH-1:0]    north_data_o_wght,
    output logic                     north_enable_o_wght,
    output logic [DATA_WIDTH-1:0]    south_data_o_wght,
    output logic                     south_enable_o_wght,
    output logic [DATA_WIDTH-1:0]    east_data_o_wght,
    output logic                     east_enable_o_wght,
    output logic [DATA_WIDTH-1:0]    west_data_o_wght,
    output logic                     west_enable_o_wght,
    output logic [DATA_WIDTH-1:0]    north_data_o_psum,
    output logic                     north_enable_o_psum,
    output logic [DATA_WIDTH-1:0]    south_data_o_psum,
    output logic                     south_enable_o_psum,
    output logic [DATA_WIDTH-1:0]    east_data_o_psum,
    output logic                     east_enable_o_psum
);
    logic [DATA_BITWIDTH-1:0] r_data_iact;
    logic [DATA_BITWIDTH-1:0] r_data_wght;
    logic [DATA_WIDTH-1:0]    psum_west_data;
    logic                     psum_west_enable;

    glb_router_cluster_bank #(.DW(DATA_BITWIDTH), .AW(ADDR_BITWIDTH), .NB(NUM_GLB_IACT)) u_bank_iact (
        .clk(clk), .rst(reset),
        .we_i(write_en_iact), .waddr_i(w_addr_iact), .wdata_i(w_data_iact),
        .re_i(read_req_iact), .raddr_i(r_addr_iact), .rdata_o(r_data_iact)
    );

    glb_router_cluster_bank #(.DW(DATA_BITWIDTH), .AW(ADDR_BITWIDTH), .NB(NUM_GLB_WGHT)) u_bank_wght (
        .clk(clk), .rst(reset),
        .we_i(write_en_wght), .waddr_i(w_addr_wght), .wdata_i(w_data_wght),
        .re_i(read_req_wght), .raddr_i(r_addr_wght), .rdata_o(r_data_wght)
    );

    // The psum bank is filled only by whatever the psum router sends west.
    glb_router_cluster_bank #(.DW(DATA_BITWIDTH), .AW(ADDR_BITWIDTH), .NB(NUM_GLB_PSUM)) u_bank_psum (
        .clk(clk), .rst(reset),
        .we_i(psum_west_enable), .waddr_i(w_addr_psum), .wdata_i(psum_west_data),
        .re_i(read_req_psum), .raddr_i(r_addr_psum), .rdata_o(r_data_psum)
    );

    glb_router_cluster_router #(.DW(DATA_WIDTH)) u_router_iact (
        .mode_i(router_mode_iact),
        .west_data_i(r_data_iact),         .west_enable_i(west_enable_i_iact),
        .east_data_i(east_data_i_iact),    .east_enable_i(east_enable_i_iact),
        .north_data_i(north_data_i_iact),  .north_enable_i(north_enable_i_iact),
        .south_data_i(south_data_i_iact),  .south_enable_i(south_enable_i_iact),
        .west_data_o(west_data_o_iact),    .west_enable_o(west_enable_o_iact),
        .east_data_o(east_data_o_iact),    .east_enable_o(east_enable_o_iact),
        .north_data_o(north_data_o_iact),  .north_enable_o(north_enable_o_iact),
        .south_data_o(south_data_o_iact),  .south_enable_o(south_enable_o_iact)
    );

    glb_router_cluster_router #(.DW(DATA_WIDTH)) u_router_wght (
        .mode_i(router_mode_wght),
        .west_data_i(r_data_wght),         .west_enable_i(west_enable_i_wght),
        .east_data_i(east_data_i_wght),    .east_enable_i(east_enable_i_wght),
        .north_data_i(north_data_i_wght),  .north_enable_i(north_enable_i_wght),
        .south_data_i(south_data_i_wght),  .south_enable_i(south_enable_i_wght),
        .west_data_o(west_data_o_wght),    .west_enable_o(west_enable_o_wght),
        .east_data_o(east_data_o_wght),    .east_enable_o(east_enable_o_wght),
        .north_data_o(north_data_o_wght),  .north_enable_o(north_enable_o_wght),
        .south_data_o(south_data_o_wght),  .south_enable_o(south_enable_o_wght)
    );

    glb_router_cluster_router #(.DW(DATA_WIDTH)) u_router_psum (
        .mode_i(router_mode_psum),
        .west_data_i(west_data_i_psum),    .west_enable_i(west_enable_i_psum),
        .east_data_i(east_data_i_psum),    .east_enable_i(east_enable_i_psum),
        .north_data_i(north_data_i_psum),  .north_enable_i(north_enable_i_psum),
        .south_data_i(south_data_i_psum),  .south_enable_i(south_enable_i_psum),
        .west_data_o(psum_west_data),      .west_enable_o(psum_west_enable),
        .east_data_o(east_data_o_psum),    .east_enable_o(east_enable_o_psum),
        .north_data_o(north_data_o_psum),  .north_enable_o(north_enable_o_psum),
        .south_data_o(south_data_o_psum),  .south_enable_o(south_enable_o_psum)
    );
endmodule

// File: tb/tb_glb_router_cluster.sv
// Bench for glb_router_cluster: reference model of banks and routing rules checked every
// cycle, plus hand-computed expectations for the directed scenarios.

module tb_glb_router_cluster;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read_req_iact, read_req_wght, read_req_psum;
    logic [9:0]  r_addr_iact, r_addr_wght, r_addr_psum;
    logic        write_en_iact, write_en_wght;
    logic [9:0]  w_addr_iact, w_addr_wght, w_addr_psum;
    logic [15:0] w_data_iact, w_data_wght;
    logic [15:0] r_data_psum;
    logic [3:0]  router_mode_iact, router_mode_wght, router_mode_psum;
    logic [15:0] north_data_i_iact, south_data_i_iact, east_data_i_iact;
    logic        north_enable_i_iact, south_enable_i_iact, east_enable_i_iact, west_enable_i_iact;
    logic [15:0] north_data_i_wght, south_data_i_wght, east_data_i_wght;
    logic        north_enable_i_wght, south_enable_i_wght, east_enable_i_wght, west_enable_i_wght;
    logic [15:0] north_data_i_psum, south_data_i_psum, east_data_i_psum, west_data_i_psum;
    logic        north_enable_i_psum, south_enable_i_psum, east_enable_i_psum, west_enable_i_psum;
    logic [15:0] north_data_o_iact, south_data_o_iact, east_data_o_iact, west_data_o_iact;
    logic        north_enable_o_iact, south_enable_o_iact, east_enable_o_iact, west_enable_o_iact;
    logic [15:0] north_data_o_wght, south_data_o_wght, east_data_o_wght, west_data_o_wght;
    logic        north_enable_o_wght, south_enable_o_wght, east_enable_o_wght, west_enable_o_wght;
    logic [15:0] north_data_o_psum, south_data_o_psum, east_data_o_psum;
    logic        north_enable_o_psum, south_enable_o_psum, east_enable_o_psum;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    glb_router_cluster dut (
        .clk(clk), .reset(reset),
        .read_req_iact(read_req_iact), .read_req_wght(read_req_wght), .read_req_psum(read_req_psum),
        .r_addr_iact(r_addr_iact), .r_addr_wght(r_addr_wght), .r_addr_psum(r_addr_psum),
        .write_en_iact(write_en_iact), .write_en_wght(write_en_wght),
        .w_addr_iact(w_addr_iact), .w_addr_wght(w_addr_wght), .w_addr_psum(w_addr_psum),
        .w_data_iact(w_data_iact), .w_data_wght(w_data_wght), .r_data_psum(r_data_psum),
        .router_mode_iact(router_mode_iact), .router_mode_wght(router_mode_wght),
        .router_mode_psum(router_mode_psum),
        .north_data_i_iact(north_data_i_iact), .north_enable_i_iact(north_enable_i_iact),
        .south_data_i_iact(south_data_i_iact), .south_enable_i_iact(south_enable_i_iact),
        .east_data_i_iact(east_data_i_iact), .east_enable_i_iact(east_enable_i_iact),
        .west_enable_i_iact(west_enable_i_iact),
        .north_data_i_wght(north_data_i_wght), .north_enable_i_wght(north_enable_i_wght),
        .south_data_i_wght(south_data_i_wght), .south_enable_i_wght(south_enable_i_wght),
        .east_data_i_wght(east_data_i_wght), .east_enable_i_wght(east_enable_i_wght),
        .west_enable_i_wght(west_enable_i_wght),
        .north_data_i_psum(north_data_i_psum), .north_enable_i_psum(north_enable_i_psum),
        .south_data_i_psum(south_data_i_psum), .south_enable_i_psum(south_enable_i_psum),
        .east_data_i_psum(east_data_i_psum), .east_enable_i_psum(east_enable_i_psum),
        .west_data_i_psum(west_data_i_psum), .west_enable_i_psum(west_enable_i_psum),
        .north_data_o_iact(north_data_o_iact), .north_enable_o_iact(north_enable_o_iact),
        .south_data_o_iact(south_data_o_iact), .south_enable_o_iact(south_enable_o_iact),
        .east_data_o_iact(east_data_o_iact), .east_enable_o_iact(east_enable_o_iact),
        .west_data_o_iact(west_data_o_iact), .west_enable_o_iact(west_enable_o_iact),
        .north_data_o_wght(north_data_o_wght), .north_enable_o_wght(north_enable_o_wght),
        .south_data_o_wght(south_data_o_wght), .south_enable_o_wght(south_enable_o_wght),
        .east_data_o_wght(east_data_o_wght), .east_enable_o_wght(east_enable_o_wght),
        .west_data_o_wght(west_data_o_wght), .west_enable_o_wght(west_enable_o_wght),
        .north_data_o_psum(north_data_o_psum), .north_enable_o_psum(north_enable_o_psum),
        .south_data_o_psum(south_data_o_psum), .south_enable_o_psum(south_enable_o_psum),
        .east_data_o_psum(east_data_o_psum), .east_enable_o_psum(east_enable_o_psum)
    );

    // ---------------- reference model ----------------
    // Port numbering here: 0=north, 1=south, 2=east, 3=west.
    function automatic logic [16:0] route_out(input logic [3:0] mode, input int port,
                                              input logic [3:0][15:0] d, input logic [3:0] en);
        int src;
        int dest;
        int order [4];
        int fsrc [6];
        int fdst [6];
        order = '{3, 2, 0, 1};
        fsrc  = '{2, 2, 2, 3, 3, 3};
        fdst  = '{0, 1, 3, 0, 1, 2};
        src = -1;
        if (mode == 4'd0) begin
            if (port != 3) src = 3;
        end else if (mode >= 4'd1 && mode <= 4'd4) begin
            dest = (mode == 4'd1) ? 0 : (mode == 4'd2) ? 1 : (mode == 4'd3) ? 3 : 2;
            if (port == dest)
                for (int k = 0; k < 4; k++)
                    if (src < 0 && en[order[k]]) src = order[k];
        end else if (mode >= 4'd5 && mode <= 4'd10) begin
            if (port == fdst[int'(mode) - 5]) src = fsrc[int'(mode) - 5];
        end
        if (src < 0) return 17'd0;
        return {en[src], d[src]};
    endfunction

    logic [15:0] m_iact [1024];
    logic [15:0] m_wght [1024];
    logic [15:0] m_psum [1024];
    logic [15:0] m_rd_iact = '0;
    logic [15:0] m_rd_wght = '0;
    logic [15:0] m_rd_psum = '0;
    logic [16:0] psum_w_exp;

    always_comb psum_w_exp = route_out(router_mode_psum, 3,
        {west_data_i_psum, east_data_i_psum, south_data_i_psum, north_data_i_psum},
        {west_enable_i_psum, east_enable_i_psum, south_enable_i_psum, north_enable_i_psum});

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rd_iact <= '0;
            m_rd_wght <= '0;
            m_rd_psum <= '0;
        end else begin
            if (read_req_iact) m_rd_iact <= m_iact[r_addr_iact];
            if (read_req_wght) m_rd_wght <= m_wght[r_addr_wght];
            if (read_req_psum) m_rd_psum <= m_psum[r_addr_psum];
            if (write_en_iact) m_iact[w_addr_iact] <= w_data_iact;
            if (write_en_wght) m_wght[w_addr_wght] <= w_data_wght;
            if (psum_w_exp[16]) m_psum[w_addr_psum] <= psum_w_exp[15:0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_router(input string nm, input logic [3:0] mode,
                                input logic [3:0][15:0] d, input logic [3:0] en,
                                input logic [3:0][15:0] ad, input logic [3:0] ae, input bit has_west);
        logic [16:0] e;
        for (int p = 0; p < 4; p++) begin
            if (p != 3 || has_west) begin
                e = route_out(mode, p, d, en);
                chk($sformatf("%s_port%0d", nm, p), {15'd0, ae[p], ad[p]}, {15'd0, e});
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check_router("iact", router_mode_iact,
                {m_rd_iact, east_data_i_iact, south_data_i_iact, north_data_i_iact},
                {west_enable_i_iact, east_enable_i_iact, south_enable_i_iact, north_enable_i_iact},
                {west_data_o_iact, east_data_o_iact, south_data_o_iact, north_data_o_iact},
                {west_enable_o_iact, east_enable_o_iact, south_enable_o_iact, north_enable_o_iact}, 1'b1);
            check_router("wght", router_mode_wght,
                {m_rd_wght, east_data_i_wght, south_data_i_wght, north_data_i_wght},
                {west_enable_i_wght, east_enable_i_wght, south_enable_i_wght, north_enable_i_wght},
                {west_data_o_wght, east_data_o_wght, south_data_o_wght, north_data_o_wght},
                {west_enable_o_wght, east_enable_o_wght, south_enable_o_wght, north_enable_o_wght}, 1'b1);
            check_router("psum", router_mode_psum,
                {west_data_i_psum, east_data_i_psum, south_data_i_psum, north_data_i_psum},
                {west_enable_i_psum, east_enable_i_psum, south_enable_i_psum, north_enable_i_psum},
                {16'd0, east_data_o_psum, south_data_o_psum, north_data_o_psum},
                {1'b0, east_enable_o_psum, south_enable_o_psum, north_enable_o_psum}, 1'b0);
            chk("r_data_psum_model", {16'd0, r_data_psum}, {16'd0, m_rd_psum});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {read_req_iact, read_req_wght, read_req_psum} = '0;
        {r_addr_iact, r_addr_wght, r_addr_psum} = '0;
        {write_en_iact, write_en_wght} = '0;
        {w_addr_iact, w_addr_wght, w_addr_psum} = '0;
        {w_data_iact, w_data_wght} = '0;
        router_mode_iact = 4'd15; router_mode_wght = 4'd15; router_mode_psum = 4'd15;
        {north_data_i_iact, south_data_i_iact, east_data_i_iact} = '0;
        {north_enable_i_iact, south_enable_i_iact, east_enable_i_iact, west_enable_i_iact} = '0;
        {north_data_i_wght, south_data_i_wght, east_data_i_wght} = '0;
        {north_enable_i_wght, south_enable_i_wght, east_enable_i_wght, west_enable_i_wght} = '0;
        {north_data_i_psum, south_data_i_psum, east_data_i_psum, west_data_i_psum} = '0;
        {north_enable_i_psum, south_enable_i_psum, east_enable_i_psum, west_enable_i_psum} = '0;
        #1 reset = 1'b1;
        chk_on = 1'b1;
        router_mode_iact = 4'd3; west_enable_i_iact = 1'b1;
        @(negedge clk);
        chk("reset_r_data_psum", {16'd0, r_data_psum}, 32'd0);
        chk("reset_west_iact", {15'd0, west_enable_o_iact, west_data_o_iact}, 32'h0001_0000);
        $display("[TB] reset state checked");
        cyc(); cyc();
        reset = 1'b0; router_mode_iact = 4'd15; west_enable_i_iact = 1'b0;

        // Fill iact/wght, plus the top address.
        for (int i = 0; i < 25; i++) begin
            write_en_iact = 1'b1; w_addr_iact = 10'(i); w_data_iact = 16'(2 * i);
            write_en_wght = 1'b1; w_addr_wght = 10'(i); w_data_wght = 16'(3 * i);
            cyc();
        end
        write_en_wght = 1'b0;
        w_addr_iact = 10'd1023; w_data_iact = 16'h1234;
        cyc();
        write_en_iact = 1'b0;
        $display("[TB] wrote iact/wght banks");

        read_req_iact = 1'b1; r_addr_iact = 10'd3;
        cyc();
        read_req_iact = 1'b0; router_mode_iact = 4'd4; west_enable_i_iact = 1'b1;
        @(negedge clk);
        chk("t1_east_iact", {15'd0, east_enable_o_iact, east_data_o_iact}, 32'h0001_0006);
        chk("t1_north_iact", {15'd0, north_enable_o_iact, north_data_o_iact}, 32'd0);
        chk("t1_west_iact", {15'd0, west_enable_o_iact, west_data_o_iact}, 32'd0);
        $display("[TB] iact addr 3 routed east");
        cyc();
        west_enable_i_iact = 1'b0; router_mode_iact = 4'd15;

        read_req_wght = 1'b1; r_addr_wght = 10'd5;
        cyc();
        read_req_wght = 1'b0; router_mode_wght = 4'd8; west_enable_i_wght = 1'b1;
        @(negedge clk);
        chk("t2_north_wght", {15'd0, north_enable_o_wght, north_data_o_wght}, 32'h0001_000F);
        #1 router_mode_wght = 4'd2;
        #1 chk("t2_south_wght", {15'd0, south_enable_o_wght, south_data_o_wght}, 32'h0001_000F);
        chk("t2_north_off", {15'd0, north_enable_o_wght, north_data_o_wght}, 32'd0);
        // Priority among non-west sources, then no source at all.
        west_enable_i_wght = 1'b0; router_mode_wght = 4'd1;
        east_data_i_wght = 16'h11; east_enable_i_wght = 1'b1;
        south_data_i_wght = 16'h22; south_enable_i_wght = 1'b1;
        north_data_i_wght = 16'h33;
        #1 chk("prio_east", {15'd0, north_enable_o_wght, north_data_o_wght}, 32'h0001_0011);
        east_enable_i_wght = 1'b0;
        #1 chk("prio_south", {15'd0, north_enable_o_wght, north_data_o_wght}, 32'h0001_0022);
        south_enable_i_wght = 1'b0;
        #1 chk("prio_none", {15'd0, north_enable_o_wght, north_data_o_wght}, 32'd0);
        $display("[TB] wght routing and priority checked");
        cyc();
        {east_data_i_wght, south_data_i_wght, north_data_i_wght} = '0;
        router_mode_wght = 4'd15;

        router_mode_psum = 4'd3;
        for (int i = 0; i < 8; i++) begin
            west_enable_i_psum = 1'b1; west_data_i_psum = 16'(i); w_addr_psum = 10'(i);
            cyc();
        end
        west_enable_i_psum = 1'b0;
        read_req_psum = 1'b1; r_addr_psum = 10'd4;
        cyc();
        read_req_psum = 1'b0;
        @(negedge clk);
        chk("t3_psum_read4", {16'd0, r_data_psum}, 32'd4);
        cyc();
        // Read and write the same address in one cycle: old word first.
        read_req_psum = 1'b1; r_addr_psum = 10'd6;
        west_enable_i_psum = 1'b1; west_data_i_psum = 16'd99; w_addr_psum = 10'd6;
        cyc();
        west_enable_i_psum = 1'b0;
        @(negedge clk);
        chk("rw_same_old", {16'd0, r_data_psum}, 32'd6);
        cyc();
        read_req_psum = 1'b0;
        @(negedge clk);
        chk("rw_same_new", {16'd0, r_data_psum}, 32'd99);
        $display("[TB] psum bank written via router");
        cyc();

        write_en_iact = 1'b0; w_addr_iact = 10'd1; w_data_iact = 16'd200;
        cyc();
        read_req_iact = 1'b1; r_addr_iact = 10'd1;
        cyc();
        read_req_iact = 1'b0; router_mode_iact = 4'd4; west_enable_i_iact = 1'b1;
        @(negedge clk);
        chk("t4_no_write", {15'd0, east_enable_o_iact, east_data_o_iact}, 32'h0001_0002);
        cyc();
        read_req_iact = 1'b1; r_addr_iact = 10'd1023;
        cyc();
        read_req_iact = 1'b0;
        @(negedge clk);
        chk("top_addr", {15'd0, east_enable_o_iact, east_data_o_iact}, 32'h0001_1234);
        $display("[TB] write-disable and top address checked");
        cyc();

        router_mode_psum = 4'd0; west_data_i_psum = 16'h00AB; west_enable_i_psum = 1'b1;
        @(negedge clk);
        chk("t5_all_north", {15'd0, north_enable_o_psum, north_data_o_psum}, 32'h0001_00AB);
        chk("t5_all_south", {15'd0, south_enable_o_psum, south_data_o_psum}, 32'h0001_00AB);
        chk("t5_all_east", {15'd0, east_enable_o_psum, east_data_o_psum}, 32'h0001_00AB);
        #1 router_mode_psum = 4'd12;
        #1 chk("t5_mode12", {13'd0, north_enable_o_psum, south_enable_o_psum, east_enable_o_psum,
                             north_data_o_psum | south_data_o_psum | east_data_o_psum}, 32'd0);
        $display("[TB] broadcast and invalid mode checked");
        cyc();
        west_enable_i_psum = 1'b0; west_data_i_psum = '0; router_mode_psum = 4'd15;

        read_req_psum = 1'b1; r_addr_psum = 10'd5;
        read_req_iact = 1'b1; r_addr_iact = 10'd3;
        cyc();
        read_req_psum = 1'b0; read_req_iact = 1'b0;
        #1 chk("t6_pre_psum", {16'd0, r_data_psum}, 32'd5);
        chk("t6_pre_iact", {16'd0, east_data_o_iact}, 32'd6);
        #1 reset = 1'b1;
        #1 chk("t6_rst_psum", {16'd0, r_data_psum}, 32'd0);
        chk("t6_rst_iact", {15'd0, east_enable_o_iact, east_data_o_iact}, 32'h0001_0000);
        cyc(); cyc();
        reset = 1'b0;
        read_req_psum = 1'b1; r_addr_psum = 10'd5;
        read_req_iact = 1'b1; r_addr_iact = 10'd24;
        cyc();
        read_req_psum = 1'b0; read_req_iact = 1'b0;
        @(negedge clk);
        chk("t6_after_psum", {16'd0, r_data_psum}, 32'd5);
        chk("t6_after_iact", {16'd0, east_data_o_iact}, 32'd48);
        $display("[TB] async reset mid-read checked");
        cyc();
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
